tape_in_cond: RTL

Cassette-input conditioner that sits between the raw tape pin (AUDIO_IN or UART_RX) and the ht1080z cassette port. It synchronises and glitch-filters the asynchronous input and produces a clean level plus one-cycle edge strobes. It also measures the clock count between clean edges and runs a carrier-detect FSM. The FSM drives the tape-activity LED and gates the tape-sound mix.

---
 rtl/tape_pkg.sv | 22 ++
 rtl/tape_glitch_filter.sv | 52 +++++
 rtl/tape_in_cond.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the cassette-input conditioner.
// Holds the carrier-detect FSM state type and the default timing
// constants for a 42 MHz system clock.
package tape_pkg;

  // Carrier-detect FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    LOCK = 2'd2
  } tape_state_t;

  // Default timings at 42 MHz.
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 16;
  localparam int DEF_CNT_W       = 18;
  localparam int DEF_MIN_W       = 400;      // ~9.5 us
  localparam int DEF_MAX_W       = 120000;   // ~2.9 ms
  localparam int DEF_LOCK_PULSES = 8;
  localparam int DEF_TIMEOUT     = 168000;   // 4 ms without an edge

endpackage

// File: rtl/tape_glitch_filter.sv
// Synchroniser plus stable-count glitch filter for the raw tape pin.
// Latency: SYNC_STAGES + FILT_LEN clocks from a held raw change to clean.
// No backpressure; flip is a combinational look-ahead of the next clean change.
//
// Ports:
//   clk42m, reset_n : clock, asynchronous active-low reset
//   din             : asynchronous raw input
//   clean           : filtered level (registered)
//   flip            : high in the cycle before clean toggles
module tape_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 16
) (
  input  logic clk42m,
  input  logic reset_n,
  input  logic din,
  output logic clean,
  output logic flip
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] STABLE_LAST = FCW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FCW-1:0]         stable_q;

  assign s = sync_q[SYNC_STAGES-1];

  // The synchronised level has disagreed with clean for FILT_LEN clocks
  // (counting this one), so clean takes the new level at the next edge.
  assign flip = (s != clean) && (stable_q == STABLE_LAST);

  always_ff @(posedge clk42m or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      stable_q <= '0;
      clean    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (s == clean) begin
        stable_q <= '0;
      end else if (flip) begin
        clean    <= s;
        stable_q <= '0;
      end else begin
        stable_q <= stable_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tape_in_cond.sv
// Cassette-input conditioner: clean level, edge strobes, edge-to-edge
// width measurement and carrier detection for the tape port.
// Latency: strobes SYNC_STAGES+FILT_LEN clocks after a held raw change;
// no backpressure (strobes are single-cycle, consumer must sample them).
//
// Ports:
//   clk42m, reset_n : 42 MHz clock, asynchronous active-low reset
//   enable          : motor/input enable; 0 parks FSM in IDLE, hides strobes
//   cass_raw        : asynchronous tape input
//   cass_clean      : filtered level (tracks regardless of enable)
//   edge_rise/fall  : one-cycle strobes on clean transitions
//   pulse_width     : clocks between the last two gated edges
//   pulse_valid     : one-cycle strobe, pulse_width updated
//   carrier         : carrier present (FSM in LOCK)
module tape_in_cond
  import tape_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_W       = DEF_MIN_W,
  parameter int MAX_W       = DEF_MAX_W,
  parameter int LOCK_PULSES = DEF_LOCK_PULSES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk42m,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cass_raw,
  output logic             cass_clean,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [CNT_W-1:0] pulse_width,
  output logic             pulse_valid,
  output logic             carrier
);

  localparam int GW = $clog2(LOCK_PULSES + 1);
  localparam logic [GW-1:0]    GOOD_MAX  = GW'(LOCK_PULSES);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_PULSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0]      MIN_U     = 32'(MIN_W);
  localparam logic [31:0]      MAX_U     = 32'(MAX_W);
  localparam logic [31:0]      TIMEOUT_U = 32'(TIMEOUT);

  logic             flip;
  logic             edge_g;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      cnt_ext;
  logic             in_range;
  logic             timed_out;

  tape_state_t   state_q, state_d;
  logic [GW-1:0] good_q, good_d;

  tape_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt (
    .clk42m  (clk42m),
    .reset_n (reset_n),
    .din     (cass_raw),
    .clean   (cass_clean),
    .flip    (flip)
  );

  // Only edges seen while enabled count as strobes, widths or FSM events.
  assign edge_g = flip & enable;

  // cnt_q is the width about to be latched, so range check and timeout
  // both look at it directly rather than at pulse_width.
  assign cnt_ext   = 32'(cnt_q);
  assign in_range  = (cnt_ext >= MIN_U) && (cnt_ext <= MAX_U);
  assign timed_out = (cnt_ext >= TIMEOUT_U);

  // Period counter, strobes and width register.
  always_ff @(posedge clk42m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      pulse_width <= '0;
      pulse_valid <= 1'b0;
      edge_rise   <= 1'b0;
      edge_fall   <= 1'b0;
    end else begin
      // clean is about to flip, so its current value gives the direction.
      edge_rise   <= edge_g & ~cass_clean;
      edge_fall   <= edge_g &  cass_clean;
      pulse_valid <= edge_g;
      if (edge_g) begin
        pulse_width <= cnt_q;
        cnt_q       <= CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Carrier FSM state register.
  always_ff @(posedge clk42m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Carrier FSM next state. An edge in the same cycle as a timeout wins.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (!enable) begin
      state_d = IDLE;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          good_d = '0;
          // Seed edge: its width is stale and deliberately ignored.
          if (edge_g) state_d = SEEK;
        end
        SEEK: begin
          if (edge_g) begin
            if (in_range) begin
              if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
              if (good_q >= GOOD_LAST) state_d = LOCK;
            end else begin
              good_d = '0;
            end
          end else if (timed_out) begin
            state_d = IDLE;
            good_d  = '0;
          end
        end
        LOCK: begin
          // Out-of-range widths are tolerated once locked.
          if (!edge_g && timed_out) begin
            state_d = IDLE;
            good_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  assign carrier = (state_q == LOCK);

endmodule
